// File: rtl/tdm_demux_1x4_pkg.sv
// Shared constants for the 1:4 TDM demultiplexer: FSM encodings and default sizing.
package tdm_demux_1x4_pkg;

   localparam logic HUNT   = 1'b0;
   localparam logic LOCKED = 1'b1;

   localparam int N_CH_DEF  = 4;
   localparam int SEL_W_DEF = 2;
   localparam int DW_DEF    = 1;

endpackage

// File: rtl/tdm_demux_1x4_slot_counter.sv
// Channel slot counter with clear, load-to-1 and increment controls plus a
// terminal-count flag for the last channel of a frame.
module tdm_slot_counter
   import tdm_demux_1x4_pkg::*;
#(
   parameter int N_CH  = N_CH_DEF,
   parameter int SEL_W = SEL_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load1,
   input  logic             en,
   output logic [SEL_W-1:0] cnt,
   output logic             tc
);

   logic [SEL_W-1:0] cnt_d;
   logic [SEL_W-1:0] cnt_q;

   // Next count: clear wins over load, load wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {SEL_W{1'b0}};
      end else if (load1) begin
         cnt_d = SEL_W'(1);
      end else if (en) begin
         cnt_d = cnt_q + SEL_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= {SEL_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = (cnt_q == SEL_W'(N_CH - 1));

endmodule

// File: rtl/tdm_demux_1x4.sv
// 1:4 time-division demultiplexer: assembles synced serial beats into a
// registered parallel frame, with frame lock tracking and framing-error pulses.
module tdm_demux_1x4
   import tdm_demux_1x4_pkg::*;
#(
   parameter int N_CH  = N_CH_DEF,
   parameter int SEL_W = SEL_W_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DW-1:0]       din,
   input  logic                din_valid,
   input  logic                sync,
   output logic [N_CH*DW-1:0]  y,
   output logic [SEL_W-1:0]    s,
   output logic                locked,
   output logic                frame_valid,
   output logic                sync_err
);

   localparam int SH_W = (N_CH - 1) * DW;

   logic                state_d, state_q;
   logic [SH_W-1:0]     shadow_d, shadow_q;
   logic [N_CH*DW-1:0]  y_d, y_q;
   logic                frame_valid_d, frame_valid_q;
   logic                sync_err_d, sync_err_q;
   logic                cnt_clr, cnt_load1, cnt_en, cnt_tc;

   tdm_slot_counter #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_slot_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .load1 (cnt_load1),
      .en    (cnt_en),
      .cnt   (s),
      .tc    (cnt_tc)
   );

   // Beat decode: only valid beats move the FSM, shadow, slot counter or y.
   always_comb begin
      state_d       = state_q;
      shadow_d      = shadow_q;
      y_d           = y_q;
      frame_valid_d = 1'b0;
      sync_err_d    = 1'b0;
      cnt_clr       = 1'b0;
      cnt_load1     = 1'b0;
      cnt_en        = 1'b0;
      if (din_valid) begin
         if (sync) begin
            // A sync beat is always channel 0; mid-frame it abandons the partial frame.
            sync_err_d          = (state_q == LOCKED) && (s != {SEL_W{1'b0}});
            shadow_d[0 +: DW]   = din;
            cnt_load1           = 1'b1;
            state_d             = LOCKED;
         end else if (state_q == HUNT) begin
            state_d = HUNT;
         end else if (s == {SEL_W{1'b0}}) begin
            sync_err_d = 1'b1;
            cnt_clr    = 1'b1;
            state_d    = HUNT;
         end else if (cnt_tc) begin
            y_d           = {din, shadow_q};
            frame_valid_d = 1'b1;
            cnt_clr       = 1'b1;
         end else begin
            for (int k = 0; k < N_CH - 1; k++) begin
               shadow_d[k*DW +: DW] = (s == SEL_W'(k)) ? din : shadow_q[k*DW +: DW];
            end
            cnt_en = 1'b1;
         end
      end else begin
         state_d = state_q;
      end
   end

   // State, shadow and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= HUNT;
         shadow_q      <= {SH_W{1'b0}};
         y_q           <= {(N_CH*DW){1'b0}};
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         shadow_q      <= shadow_d;
         y_q           <= y_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
      end
   end

   assign y           = y_q;
   assign locked      = (state_q == LOCKED);
   assign frame_valid = frame_valid_q;
   assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Bench for tdm_demux_1x4: directed framing scenarios plus random beats, all
// checked against a queue-based frame assembly model.
module tb_tdm_demux_1x4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [0:0] din = 1'b0;
   logic       din_valid = 1'b0;
   logic       sync = 1'b0;
   logic [3:0] y;
   logic [1:0] s;
   logic       locked, frame_valid, sync_err;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int fv_cyc[$];

   // Reference model: the samples collected so far for the current frame.
   bit         m_locked;
   bit         m_q[$];
   logic [3:0] m_y;
   bit         m_fv, m_err;

   tdm_demux_1x4 dut (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .din_valid   (din_valid),
      .sync        (sync),
      .y           (y),
      .s           (s),
      .locked      (locked),
      .frame_valid (frame_valid),
      .sync_err    (sync_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_locked = 1'b0;
      m_q.delete();
      m_y   = 4'b0000;
      m_fv  = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic model_step(input bit v, input bit sy, input bit d);
      m_fv  = 1'b0;
      m_err = 1'b0;
      if (v) begin
         if (sy) begin
            if (m_locked && m_q.size() != 0) m_err = 1'b1;
            m_q.delete();
            m_q.push_back(d);
            m_locked = 1'b1;
         end else if (m_locked) begin
            if (m_q.size() == 0) begin
               m_err    = 1'b1;
               m_locked = 1'b0;
            end else begin
               m_q.push_back(d);
               if (m_q.size() == 4) begin
                  for (int i = 0; i < 4; i++) m_y[i] = m_q[i];
                  m_fv = 1'b1;
                  m_q.delete();
               end
            end
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check_eq({tag, ".y"}, 32'(y), 32'(m_y));
      check_eq({tag, ".s"}, 32'(s), 32'(m_q.size()));
      check_eq({tag, ".locked"}, 32'(locked), 32'(m_locked));
      check_eq({tag, ".fv"}, 32'(frame_valid), 32'(m_fv));
      check_eq({tag, ".err"}, 32'(sync_err), 32'(m_err));
   endtask

   // Drive one cycle of inputs, step the model on the edge, compare just after it.
   task automatic beat(input string tag, input bit v, input bit sy, input bit d);
      din_valid = v;
      sync      = sy;
      din       = d;
      @(posedge clk);
      cyc++;
      model_step(v, sy, d);
      #1;
      compare_all(tag);
      if (frame_valid) fv_cyc.push_back(cyc);
   endtask

   task automatic send_frame(input string tag, input logic [3:0] f);
      for (int i = 0; i < 4; i++) beat(tag, 1'b1, (i == 0), f[i]);
   endtask

   initial begin
      model_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      compare_all("in_reset");
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) beat("idle", 1'b0, 1'b0, 1'b0);

      // Clean frame 1,0,1,1
      fv_cyc.delete();
      beat("clean", 1'b1, 1'b1, 1'b1);
      check_eq("clean_lock_b0", 32'(locked), 32'd1);
      beat("clean", 1'b1, 1'b0, 1'b0);
      beat("clean", 1'b1, 1'b0, 1'b1);
      beat("clean", 1'b1, 1'b0, 1'b1);
      check_eq("clean_y", 32'(y), 32'hD);
      check_eq("clean_fv", 32'(frame_valid), 32'd1);
      check_eq("clean_s0", 32'(s), 32'd0);
      beat("clean_tail", 1'b0, 1'b0, 1'b0);
      check_eq("clean_fv_width", 32'(frame_valid), 32'd0);

      // Back-to-back frames
      fv_cyc.delete();
      send_frame("b2b_a", 4'b1101);
      check_eq("b2b_y1", 32'(y), 32'hD);
      send_frame("b2b_b", 4'b0110);
      check_eq("b2b_y2", 32'(y), 32'h6);
      check_eq("b2b_npulse", 32'(fv_cyc.size()), 32'd2);
      if (fv_cyc.size() == 2) check_eq("b2b_gap", 32'(fv_cyc[1] - fv_cyc[0]), 32'd4);

      // Early sync abandons the partial frame
      fv_cyc.delete();
      beat("early", 1'b1, 1'b1, 1'b1);
      beat("early", 1'b1, 1'b0, 1'b1);
      beat("early", 1'b1, 1'b1, 1'b0);
      check_eq("early_err", 32'(sync_err), 32'd1);
      beat("early", 1'b1, 1'b0, 1'b0);
      beat("early", 1'b1, 1'b0, 1'b1);
      check_eq("early_no_fv", 32'(fv_cyc.size()), 32'd0);
      beat("early", 1'b1, 1'b0, 1'b1);
      check_eq("early_y", 32'(y), 32'hC);
      check_eq("early_fv", 32'(frame_valid), 32'd1);

      // Missing sync drops lock; gapped frame still assembles
      send_frame("miss_pre", 4'b0011);
      beat("miss", 1'b1, 1'b0, 1'b1);
      check_eq("miss_err", 32'(sync_err), 32'd1);
      check_eq("miss_unlock", 32'(locked), 32'd0);
      beat("miss_ign", 1'b1, 1'b0, 1'b1);
      beat("miss_ign", 1'b1, 1'b0, 1'b0);
      check_eq("miss_s_hold", 32'(s), 32'd0);
      beat("gap", 1'b1, 1'b1, 1'b0);
      beat("gap", 1'b0, 1'b0, 1'b0);
      beat("gap", 1'b1, 1'b0, 1'b1);
      beat("gap", 1'b0, 1'b1, 1'b1);
      beat("gap", 1'b1, 1'b0, 1'b0);
      beat("gap", 1'b0, 1'b0, 1'b0);
      beat("gap", 1'b1, 1'b0, 1'b1);
      check_eq("gap_y", 32'(y), 32'hA);

      // Asynchronous reset mid-frame
      beat("rst_mid", 1'b1, 1'b1, 1'b1);
      beat("rst_mid", 1'b1, 1'b0, 1'b1);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      compare_all("rst_async");
      @(negedge clk);
      reset = 1'b0;
      beat("rst_after", 1'b1, 1'b0, 1'b1);
      beat("rst_after", 1'b1, 1'b0, 1'b1);
      check_eq("rst_y_hold0", 32'(y), 32'd0);
      send_frame("rst_new", 4'b1001);
      check_eq("rst_new_y", 32'(y), 32'h9);

      // Random beats against the model
      for (int i = 0; i < 600; i++) begin
         beat("rand", ($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 2), 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
